// File: rtl/finalprojsoc_pio_pkg.sv
// rtl/finalprojsoc_pio_pkg.sv - shared constants for the interrupting input PIO
package finalprojsoc_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/finalprojsoc_pio_bit_cond.sv
// rtl/finalprojsoc_pio_bit_cond.sv - per-bit synchroniser with optional debounce filter
module finalprojsoc_pio_bit_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_pin,
    output logic o_db
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE == 0) begin : g_bypass
            assign o_db = w_sync;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE + 1);
            logic [CW-1:0] r_cnt;
            logic          r_db;

            // The DEBOUNCE-th consecutive mismatching cycle is the one that commits the change.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                    r_db  <= 1'b0;
                end else if (w_sync == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == CW'(DEBOUNCE - 1)) begin
                    r_db  <= w_sync;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            assign o_db = r_db;
        end
    endgenerate

endmodule

// File: rtl/finalprojsoc_pio_in_irq.sv
// rtl/finalprojsoc_pio_in_irq.sv - Avalon-MM input port with edge capture, mask and irq
module finalprojsoc_pio_in_irq
    import finalprojsoc_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               DEBOUNCE    = 0,
    parameter int               EDGE_TYPE   = EDGE_RISING,
    parameter int               IRQ_MODE    = IRQ_EDGE,
    parameter logic [WIDTH-1:0] MASK_RESET  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [31:0] MASK32     = (WIDTH == 32) ? 32'hFFFF_FFFF
                                                       : ((32'd1 << WIDTH) - 32'd1);
    localparam logic [31:0] MASK_RST32 = 32'(MASK_RESET);
    localparam int          WARM       = SYNC_STAGES + DEBOUNCE;
    localparam int          WW         = $clog2(WARM + 1);

    logic [WIDTH-1:0] w_db;
    logic [31:0]      w_db32;
    logic [31:0]      w_edge;
    logic [31:0]      w_clr;
    logic [31:0]      w_rd;
    logic             w_wr;

    logic [WW-1:0]    r_warm;
    logic             r_prime;
    logic [31:0]      r_db_prev;
    logic [31:0]      r_edge_cap;
    logic [31:0]      r_mask;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            finalprojsoc_pio_bit_cond #(
                .SYNC_STAGES(SYNC_STAGES),
                .DEBOUNCE   (DEBOUNCE)
            ) u_cond (
                .clk    (clk),
                .reset_n(reset_n),
                .i_pin  (in_port[gi]),
                .o_db   (w_db[gi])
            );
        end
    endgenerate

    always_comb begin
        w_db32             = '0;
        w_db32[WIDTH-1:0]  = w_db;
        w_wr               = chipselect & ~write_n;
        w_clr              = (w_wr && address == ADDR_EDGE) ? (writedata & MASK32) : '0;

        w_edge = '0;
        if (r_prime) begin
            case (EDGE_TYPE)
                EDGE_FALLING: w_edge = ~w_db32 & r_db_prev;
                EDGE_ANY:     w_edge = w_db32 ^ r_db_prev;
                default:      w_edge = w_db32 & ~r_db_prev;
            endcase
        end

        case (address)
            ADDR_DATA: w_rd = w_db32;
            ADDR_MASK: w_rd = r_mask;
            ADDR_EDGE: w_rd = r_edge_cap;
            default:   w_rd = '0;
        endcase
    end

    // Prime waits until the sync chain and debounce filter have settled from their reset
    // zeros, so a pin held high through reset is not mistaken for a fresh edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_warm     <= '0;
            r_prime    <= 1'b0;
            r_db_prev  <= '0;
            r_edge_cap <= '0;
            r_mask     <= MASK_RST32;
            readdata   <= '0;
            irq        <= 1'b0;
        end else begin
            if (r_warm != WW'(WARM)) begin
                r_warm <= r_warm + WW'(1);
            end
            r_prime    <= (r_warm == WW'(WARM));
            r_db_prev  <= w_db32;
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
            if (w_wr && address == ADDR_MASK) begin
                r_mask <= writedata & MASK32;
            end
            readdata   <= w_rd;
            irq        <= (IRQ_MODE == IRQ_LEVEL) ? |(w_db32 & r_mask)
                                                  : |(r_edge_cap & r_mask);
        end
    end

endmodule

// File: tb/tb_finalprojsoc_pio_in_irq.sv
// tb/tb_finalprojsoc_pio_in_irq.sv - scoreboard bench for the interrupting input PIO
module tb_finalprojsoc_pio_in_irq;

    localparam int IE = 0;  // DEBOUNCE=0, edge irq
    localparam int ID = 1;  // DEBOUNCE=4, edge irq
    localparam int IL = 2;  // DEBOUNCE=0, level irq

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic        cs_e, cs_d, cs_l;
    logic [7:0]  in_e, in_d, in_l;
    logic [31:0] rd_e, rd_d, rd_l;
    logic        irq_e, irq_d, irq_l;

    always #5 clk = ~clk;

    finalprojsoc_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(0), .EDGE_TYPE(0),
                              .IRQ_MODE(1), .MASK_RESET(8'h00)) u_e (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_e),
        .write_n(write_n), .writedata(writedata), .in_port(in_e),
        .readdata(rd_e), .irq(irq_e));

    finalprojsoc_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(4), .EDGE_TYPE(0),
                              .IRQ_MODE(1), .MASK_RESET(8'h00)) u_d (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_d),
        .write_n(write_n), .writedata(writedata), .in_port(in_d),
        .readdata(rd_d), .irq(irq_d));

    finalprojsoc_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(0), .EDGE_TYPE(0),
                              .IRQ_MODE(0), .MASK_RESET(8'h00)) u_l (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_l),
        .write_n(write_n), .writedata(writedata), .in_port(in_l),
        .readdata(rd_l), .irq(irq_l));

    typedef struct {
        int          inst;
        bit          is_irq;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   req_cnt;
    int   n_vec;
    int   n_bad;

    task automatic tick();
        @(negedge clk);
        req_cnt = 0;
        cs_e    = 1'b0;
        cs_d    = 1'b0;
        cs_l    = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input int inst, input logic [1:0] a, input logic [31:0] d);
        case (inst)
            IE:      cs_e = 1'b1;
            ID:      cs_d = 1'b1;
            default: cs_l = 1'b1;
        endcase
        write_n   = 1'b0;
        address   = a;
        writedata = d;
    endtask

    // Each expectation describes the DUT output just after the next rising edge.
    task automatic exp_rd(input int inst, input logic [1:0] a, input logic [31:0] v,
                          input string name);
        exp_t e;
        address  = a;
        e.inst   = inst;
        e.is_irq = 1'b0;
        e.val    = v;
        e.name   = name;
        sb.push_back(e);
        req_cnt++;
    endtask

    task automatic exp_irq(input int inst, input logic v, input string name);
        exp_t e;
        e.inst   = inst;
        e.is_irq = 1'b1;
        e.val    = {31'b0, v};
        e.name   = name;
        sb.push_back(e);
        req_cnt++;
    endtask

    initial begin : monitor
        int          n;
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(posedge clk);
            n = req_cnt;
            #1;
            for (int k = 0; k < n; k++) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_underflow: response due but no expectation queued");
                end else begin
                    e = sb.pop_front();
                    case (e.inst)
                        IE:      act = e.is_irq ? {31'b0, irq_e} : rd_e;
                        ID:      act = e.is_irq ? {31'b0, irq_d} : rd_d;
                        default: act = e.is_irq ? {31'b0, irq_l} : rd_l;
                    endcase
                    if (act !== e.val) begin
                        n_bad++;
                        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset_n = 1'b0; address = 2'd0; write_n = 1'b1; writedata = '0;
        cs_e = 1'b0; cs_d = 1'b0; cs_l = 1'b0;
        in_e = 8'hFF; in_d = 8'hFF; in_l = 8'hFF;
        req_cnt = 0; n_vec = 0; n_bad = 0;
        ticks(3);
        reset_n = 1'b1;
        ticks(10);

        // pins high through reset: data follows, no edge, no irq
        exp_rd(IE, 2'd0, 32'hFF, "rst_data_e"); exp_rd(ID, 2'd0, 32'hFF, "rst_data_d");
        exp_rd(IL, 2'd0, 32'hFF, "rst_data_l");
        exp_irq(IE, 1'b0, "rst_irq_e"); exp_irq(ID, 1'b0, "rst_irq_d"); exp_irq(IL, 1'b0, "rst_irq_l");
        tick();
        exp_rd(IE, 2'd3, 32'h0, "rst_cap_e"); exp_rd(ID, 2'd3, 32'h0, "rst_cap_d");
        exp_rd(IL, 2'd3, 32'h0, "rst_cap_l");
        tick();
        exp_rd(IE, 2'd2, 32'h0, "rst_mask_e");
        tick();
        in_e = 8'h00; in_d = 8'h00; in_l = 8'h00;
        ticks(12);

        wr(IE, 2'd2, 32'hFFFF_FF08); tick();
        exp_rd(IE, 2'd2, 32'h08, "mask_upper_bits"); tick();

        // rising edge on bit3, capture, irq, W1C
        in_e = 8'h08; tick(); tick();
        exp_rd(IE, 2'd3, 32'h00, "cap_before_edge"); exp_irq(IE, 1'b0, "irq_before_edge"); tick();
        exp_rd(IE, 2'd3, 32'h08, "cap_rise_bit3");   exp_irq(IE, 1'b1, "irq_rise_bit3");   tick();
        wr(IE, 2'd3, 32'h08); exp_irq(IE, 1'b1, "irq_hold_during_w1c"); tick();
        exp_irq(IE, 1'b0, "irq_after_w1c"); exp_rd(IE, 2'd3, 32'h00, "cap_after_w1c"); tick();

        // W1C of bit2 in the cycle its edge arrives: the edge wins
        in_e = 8'h0C; tick(); tick();
        wr(IE, 2'd3, 32'h04); tick();
        exp_rd(IE, 2'd3, 32'h04, "collision_edge_wins"); exp_irq(IE, 1'b0, "collision_unmasked"); tick();
        wr(IE, 2'd3, 32'h04); tick();
        exp_rd(IE, 2'd3, 32'h00, "w1c_bit2"); tick();

        // read path
        exp_rd(IE, 2'd1, 32'h0, "rsvd_reads_0"); tick();
        wr(IE, 2'd0, 32'hFFFF_FFFF); tick();
        exp_rd(IE, 2'd0, 32'h0C, "data_write_ignored"); tick();
        wr(IE, 2'd1, 32'hFFFF_FFFF); tick();
        exp_rd(IE, 2'd1, 32'h0, "rsvd_write_ignored"); tick();
        exp_rd(IE, 2'd2, 32'h08, "latency_mask"); tick();
        exp_rd(IE, 2'd0, 32'h0C, "latency_data"); tick();
        exp_rd(IE, 2'd1, 32'h00, "latency_rsvd"); tick();

        // debounce: 3-cycle glitch rejected, 6-cycle pulse accepted
        wr(ID, 2'd2, 32'h01); tick();
        in_d = 8'h01; ticks(3); in_d = 8'h00; ticks(10);
        exp_rd(ID, 2'd0, 32'h0, "glitch_data"); tick();
        exp_rd(ID, 2'd3, 32'h0, "glitch_cap"); exp_irq(ID, 1'b0, "glitch_irq"); tick();
        in_d = 8'h01; ticks(6); in_d = 8'h00;
        exp_rd(ID, 2'd0, 32'h1, "pulse_data"); tick();
        ticks(10);
        exp_rd(ID, 2'd3, 32'h1, "pulse_cap"); exp_irq(ID, 1'b1, "pulse_irq"); tick();
        exp_rd(ID, 2'd0, 32'h0, "pulse_data_fall"); tick();

        // level mode: mask gating and sync latency on release
        in_l = 8'h01; ticks(4);
        exp_irq(IL, 1'b0, "level_masked"); tick();
        wr(IL, 2'd2, 32'h01); exp_irq(IL, 1'b0, "level_pre_unmask"); tick();
        exp_irq(IL, 1'b1, "level_unmasked"); tick();
        in_l = 8'h00; exp_irq(IL, 1'b1, "level_sync1"); tick();
        exp_irq(IL, 1'b1, "level_sync2"); tick();
        exp_irq(IL, 1'b0, "level_released"); tick();

        // reset mid-operation discards a pending edge and restores the mask
        in_e = 8'h1C; ticks(4);
        exp_rd(IE, 2'd3, 32'h10, "pending_before_reset"); tick();
        reset_n = 1'b0; tick();
        reset_n = 1'b1; ticks(10);
        exp_rd(IE, 2'd3, 32'h0, "reset_discards_cap"); exp_irq(IE, 1'b0, "reset_irq"); tick();
        exp_rd(IE, 2'd2, 32'h0, "reset_mask"); tick();

        ticks(2);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d expectations left, 0 required", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
